// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART image loader: RX state encodings and bit-period helper.
// Pure definitions, no latency; no flow control.
package imem_uart_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Integer divide on purpose; also used by the transmit side once it exists.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer plus mid-bit sampling FSM.
// byte_vld_o/frame_err_o pulse combinationally on the stop-bit sample cycle; no backpressure.
module imem_uart_loader_uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_rx_meta;
    logic             r_rx_sync;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_half;
    logic             w_full;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_byte_vld;
    logic             w_frame_err;

    assign w_half = (r_cnt == HALF_M1);
    assign w_full = (r_cnt == FULL_M1);

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            if (r_state == RX_IDLE) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_vld  = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_sync) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_half) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_full) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_full) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = RX_IDLE;
                    if (r_rx_sync) begin
                        w_byte_vld = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign byte_o      = r_shift;
    assign byte_vld_o  = w_byte_vld;
    assign frame_err_o = w_frame_err;

endmodule

// File: rtl/imem_uart_loader.sv
// UART program loader: assembles little-endian words and strobes IM writes (LOADER_CKSUM_EN adds trailing checksum byte).
// we_o rises 1 cycle after the 4th byte's stop-bit sample; no backpressure, bytes outside an active load are dropped.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_i,
    input  logic              load_en_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              cksum_err_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    logic [7:0]        w_byte;
    logic              w_byte_vld;
    logic              w_frame_err;
    logic              w_load_rise;
    logic              w_asm_vld;
    logic              w_word_done;
    logic              w_last_wr;
    logic              w_done_set;

    logic              r_load_q;
    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [23:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_frame_err;

    imem_uart_loader_uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (uart_rx_i),
        .byte_o     (w_byte),
        .byte_vld_o (w_byte_vld),
        .frame_err_o(w_frame_err)
    );

    assign w_load_rise = load_en_i & ~r_load_q;

`ifdef LOADER_CKSUM_EN
    logic       r_img_done;
    logic [7:0] r_sum;
    logic       r_cksum_err;

    // After the last word only the checksum byte is accepted; it is never assembled.
    assign w_asm_vld  = load_en_i & w_byte_vld & ~r_done & ~r_img_done;
    assign w_done_set = load_en_i & w_byte_vld & ~r_done & r_img_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_img_done  <= 1'b0;
            r_sum       <= '0;
            r_cksum_err <= 1'b0;
        end else if (!load_en_i) begin
            r_img_done  <= 1'b0;
            r_sum       <= '0;
            r_cksum_err <= 1'b0;
        end else begin
            if (w_asm_vld) begin
                r_sum <= r_sum + w_byte;
            end
            if (w_last_wr) begin
                r_img_done <= 1'b1;
            end
            if (w_done_set) begin
                r_cksum_err <= ((r_sum + w_byte) != 8'h00);
            end
        end
    end

    assign cksum_err_o = r_cksum_err;
`else
    assign w_asm_vld   = load_en_i & w_byte_vld & ~r_done;
    assign w_done_set  = w_last_wr;
    assign cksum_err_o = 1'b0;
`endif

    assign w_word_done = w_asm_vld & (r_idx == 2'd3);
    assign w_last_wr   = w_word_done & (&r_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_q    <= 1'b0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we     <= 1'b0;
            r_load_q <= load_en_i;
            if (w_load_rise) begin
                r_frame_err <= 1'b0;
            end
            if (w_frame_err) begin
                r_frame_err <= 1'b1;
            end
            if (!load_en_i) begin
                r_idx  <= '0;
                r_addr <= '0;
                r_word <= '0;
                r_done <= 1'b0;
            end else begin
                if (w_done_set) begin
                    r_done <= 1'b1;
                end
                if (w_word_done) begin
                    r_we    <= 1'b1;
                    r_waddr <= r_addr;
                    r_wdata <= {w_byte, r_word};
                    r_idx   <= '0;
                    // The address never wraps; the last slot ends the image.
                    if (!(&r_addr)) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end else if (w_asm_vld) begin
                    case (r_idx)
                        2'd0:    r_word[7:0]   <= w_byte;
                        2'd1:    r_word[15:8]  <= w_byte;
                        default: r_word[23:16] <= w_byte;
                    endcase
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    assign we_o        = r_we;
    assign waddr_o     = r_waddr;
    assign wdata_o     = r_wdata;
    assign done_o      = r_done;
    assign busy_o      = load_en_i & ~r_done;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader, using a 16-clock bit period to keep runs short.
module tb_imem_uart_loader;

    localparam int CF  = 16;
    localparam int BD  = 1;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        load_a;
    logic        load_b;

    logic        we_a, busy_a, done_a, ferr_a, cerr_a;
    logic [5:0]  waddr_a;
    logic [31:0] wdata_a;
    logic        we_b, busy_b, done_b, ferr_b, cerr_b;
    logic [1:0]  waddr_b;
    logic [31:0] wdata_b;

    int          checks = 0;
    int          errors = 0;
    int          we_cnt_a = 0;
    int          we_cnt_b = 0;
    int          byte_cnt_a = 0;
    logic [31:0] last_addr_a = '0;
    logic [31:0] last_data_a = '0;
    logic [31:0] last_addr_b = '0;
    logic [31:0] last_data_b = '0;

    always #5 clk = ~clk;

    imem_uart_loader #(.CLK_FREQ(CF), .BAUD(BD), .ADDR_W(6)) u_a (
        .clk(clk), .rst(rst), .uart_rx_i(rx), .load_en_i(load_a),
        .we_o(we_a), .waddr_o(waddr_a), .wdata_o(wdata_a), .busy_o(busy_a),
        .done_o(done_a), .frame_err_o(ferr_a), .cksum_err_o(cerr_a)
    );

    imem_uart_loader #(.CLK_FREQ(CF), .BAUD(BD), .ADDR_W(2)) u_b (
        .clk(clk), .rst(rst), .uart_rx_i(rx), .load_en_i(load_b),
        .we_o(we_b), .waddr_o(waddr_b), .wdata_o(wdata_b), .busy_o(busy_b),
        .done_o(done_b), .frame_err_o(ferr_b), .cksum_err_o(cerr_b)
    );

`ifdef LOADER_CKSUM_EN
    logic        load_c;
    logic        we_c, busy_c, done_c, ferr_c, cerr_c;
    logic [0:0]  waddr_c;
    logic [31:0] wdata_c;
    int          we_cnt_c = 0;

    imem_uart_loader #(.CLK_FREQ(CF), .BAUD(BD), .ADDR_W(1)) u_c (
        .clk(clk), .rst(rst), .uart_rx_i(rx), .load_en_i(load_c),
        .we_o(we_c), .waddr_o(waddr_c), .wdata_o(wdata_c), .busy_o(busy_c),
        .done_o(done_c), .frame_err_o(ferr_c), .cksum_err_o(cerr_c)
    );

    always @(negedge clk) begin
        if (we_c) we_cnt_c++;
    end
`endif

    always @(negedge clk) begin
        if (we_a) begin
            we_cnt_a++;
            last_addr_a = 32'(waddr_a);
            last_data_a = wdata_a;
        end
        if (we_b) begin
            we_cnt_b++;
            last_addr_b = 32'(waddr_b);
            last_data_b = wdata_b;
        end
        if (u_a.w_byte_vld) byte_cnt_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
        idle(2);
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
`ifdef LOADER_CKSUM_EN
        load_c = 1'b0;
`endif
        idle(3);
        chk("rst_we",    32'(we_a),    32'd0);
        chk("rst_waddr", 32'(waddr_a), 32'd0);
        chk("rst_wdata", wdata_a,      32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_done",  32'(done_a),  32'd0);
        chk("rst_ferr",  32'(ferr_a),  32'd0);
        chk("rst_cerr",  32'(cerr_a),  32'd0);
        rst = 1'b0;
        idle(4);

        // Basic word assembly
        load_a = 1'b1;
        idle(2);
        chk("t1_busy_pre", 32'(busy_a), 32'd1);
        send4(8'h13, 8'h05, 8'h10, 8'h00);
        idle(4);
        chk("t1_we_cnt", 32'(we_cnt_a), 32'd1);
        chk("t1_addr",   last_addr_a,   32'd0);
        chk("t1_data",   last_data_a,   32'h00100513);
        chk("t1_busy",   32'(busy_a),   32'd1);
        chk("t1_done",   32'(done_a),   32'd0);

        // Short low glitch is rejected at the start-bit midpoint
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(60);
        chk("t2_bytes",  32'(byte_cnt_a), 32'd4);
        chk("t2_we_cnt", 32'(we_cnt_a),   32'd1);
        chk("t2_ferr",   32'(ferr_a),     32'd0);

        // Framing error, then a clean word from address 0
        load_a = 1'b0;
        idle(3);
        load_a = 1'b1;
        idle(3);
        send_byte(8'h55, 1'b0);
        idle(40);
        chk("t3_ferr",   32'(ferr_a),     32'd1);
        chk("t3_bytes",  32'(byte_cnt_a), 32'd4);
        chk("t3_we_cnt", 32'(we_cnt_a),   32'd1);
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        idle(4);
        chk("t3_we_cnt2", 32'(we_cnt_a), 32'd2);
        chk("t3_addr",    last_addr_a,   32'd0);
        chk("t3_data",    last_data_a,   32'h44332211);
        chk("t3_ferr2",   32'(ferr_a),   32'd1);

        // Partial word discarded by dropping load enable
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        chk("t5_no_we", 32'(we_cnt_a), 32'd2);
        load_a = 1'b0;
        idle(3);
        chk("t5_busy_off", 32'(busy_a), 32'd0);
        load_a = 1'b1;
        idle(3);
        chk("t5_ferr_clr", 32'(ferr_a), 32'd0);
        send4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        idle(4);
        chk("t5_we_cnt", 32'(we_cnt_a), 32'd3);
        chk("t5_addr",   last_addr_a,   32'd0);
        chk("t5_data",   last_data_a,   32'hDDCCBBAA);

        load_a = 1'b0;
        idle(3);
`ifndef LOADER_CKSUM_EN
        // Full image on the 4-word instance; traffic so far was ignored by it
        chk("t4_idle_we", 32'(we_cnt_b), 32'd0);
        load_b = 1'b1;
        idle(3);
        send4(8'h00, 8'h01, 8'h02, 8'h03);
        idle(4);
        chk("t4_w0_cnt",  32'(we_cnt_b), 32'd1);
        chk("t4_w0_data", last_data_b,   32'h03020100);
        send4(8'h04, 8'h05, 8'h06, 8'h07);
        send4(8'h08, 8'h09, 8'h0A, 8'h0B);
        chk("t4_done_early", 32'(done_b), 32'd0);
        send4(8'h0C, 8'h0D, 8'h0E, 8'h0F);
        idle(4);
        chk("t4_w3_cnt",  32'(we_cnt_b), 32'd4);
        chk("t4_w3_addr", last_addr_b,   32'd3);
        chk("t4_w3_data", last_data_b,   32'h0F0E0D0C);
        chk("t4_done",    32'(done_b),   32'd1);
        chk("t4_busy",    32'(busy_b),   32'd0);
        send4(8'h10, 8'h11, 8'h12, 8'h13);
        idle(4);
        chk("t4_post_cnt",  32'(we_cnt_b), 32'd4);
        chk("t4_post_done", 32'(done_b),   32'd1);
        chk("t4_cerr",      32'(cerr_b),   32'd0);
`else
        // Two-word image followed by the checksum byte
        load_c = 1'b1;
        idle(3);
        send4(8'h01, 8'h00, 8'h00, 8'h00);
        send4(8'h02, 8'h00, 8'h00, 8'h00);
        idle(4);
        chk("t6_we_cnt",   32'(we_cnt_c), 32'd2);
        chk("t6_wait_ck",  32'(done_c),   32'd0);
        send_byte(8'hFD, 1'b1);
        idle(4);
        chk("t6_done",     32'(done_c),   32'd1);
        chk("t6_cerr_ok",  32'(cerr_c),   32'd0);
        chk("t6_we_cnt2",  32'(we_cnt_c), 32'd2);
        load_c = 1'b0;
        idle(3);
        load_c = 1'b1;
        idle(3);
        send4(8'h01, 8'h00, 8'h00, 8'h00);
        send4(8'h02, 8'h00, 8'h00, 8'h00);
        send_byte(8'hFE, 1'b1);
        idle(4);
        chk("t6_done2",    32'(done_c),   32'd1);
        chk("t6_cerr_bad", 32'(cerr_c),   32'd1);
        chk("t6_we_cnt3",  32'(we_cnt_c), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
